// File: rtl/conv_if_pkg.sv
// -----------------------------------------------------------------------------
// conv_if_pkg
// Shared definitions for the CONV host-side memory responder: data/address
// widths, bank depths, bank-select codes, controller state encoding and the
// bit positions of the sticky error flags.
// -----------------------------------------------------------------------------
package conv_if_pkg;

   localparam int DW       = 20;    // signed 4.16 fixed point, opaque here
   localparam int AW       = 12;    // address width on every CONV port
   localparam int L0_DEPTH = 4096;
   localparam int L1_DEPTH = 1024;

   localparam logic [2:0] CSEL_L0 = 3'b001;
   localparam logic [2:0] CSEL_L1 = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READY,
      ST_RUN,
      ST_DONE
   } state_t;

   // err = {timeout, protocol, addr, csel}
   localparam int ERR_CSEL  = 0;
   localparam int ERR_ADDR  = 1;
   localparam int ERR_PROTO = 2;
   localparam int ERR_TMO   = 3;

endpackage

// File: rtl/conv_bank_ram.sv
// -----------------------------------------------------------------------------
// conv_bank_ram
// Word-addressed bank with one synchronous write port and two combinational
// read ports. Addresses at or beyond DEPTH are dropped on write and read as 0.
//
// Ports:
//   clk        clock
//   we         write strobe (sampled on posedge)
//   wr_addr    write address
//   wr_data    write data
//   rd_a_addr  read port A address   -> rd_a_data (zero latency)
//   rd_b_addr  read port B address   -> rd_b_data (zero latency)
// -----------------------------------------------------------------------------
module conv_bank_ram #(
   parameter int DEPTH = 4096,
   parameter int AW    = 12,
   parameter int DW    = 20
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_a_addr,
   output logic [DW-1:0] rd_a_data,
   input  logic [AW-1:0] rd_b_addr,
   output logic [DW-1:0] rd_b_data
);

   localparam int            IW      = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_V = DEPTH[AW:0];

   logic [DW-1:0] mem [DEPTH];

   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < DEPTH_V;
   endfunction

   // NOTE: the array has no reset on purpose: contents must survive a reset
   // of the controller, and a reset loop would stop it mapping onto RAM.
   always_ff @(posedge clk) begin
      if (we && in_range(wr_addr)) begin
         mem[wr_addr[IW-1:0]] <= wr_data;
      end
   end

   assign rd_a_data = in_range(rd_a_addr) ? mem[rd_a_addr[IW-1:0]] : '0;
   assign rd_b_data = in_range(rd_b_addr) ? mem[rd_b_addr[IW-1:0]] : '0;

endmodule

// File: rtl/conv_host_mem.sv
// -----------------------------------------------------------------------------
// conv_host_mem
// Host-side responder for the CONV accelerator. Owns the 64x64 image memory
// and the two layer result banks, sequences a run (IDLE -> READY -> RUN ->
// DONE), counts accepted layer writes and keeps sticky error flags.
//
// Ports:
//   clk, reset                   clock, asynchronous active-low reset
//   ld_we/ld_addr/ld_data        host image loader (IDLE/DONE only)
//   start                        one-cycle pulse to begin a run
//   ready, busy                  handshake with CONV
//   iaddr -> idata               image read, combinational
//   cwr/caddr_wr/cdata_wr        layer write, bank chosen by csel
//   crd/caddr_rd -> cdata_rd     layer read, combinational, 0 when not valid
//   csel                         bank select (001 = L0, 011 = L1)
//   rb_sel/rb_addr -> rb_data    result readback (0 = L0, 1 = L1)
//   done                         one-cycle pulse when busy falls
//   wr_cnt_l0, wr_cnt_l1         saturating accepted-write counters
//   err                          sticky {timeout, protocol, addr, csel}
// -----------------------------------------------------------------------------
module conv_host_mem
   import conv_if_pkg::*;
#(
   parameter int RDY_TIMEOUT = 1023
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_data,
   input  logic          start,
   output logic          ready,
   input  logic          busy,
   input  logic [AW-1:0] iaddr,
   output logic [DW-1:0] idata,
   input  logic          cwr,
   input  logic [AW-1:0] caddr_wr,
   input  logic [DW-1:0] cdata_wr,
   input  logic          crd,
   input  logic [AW-1:0] caddr_rd,
   output logic [DW-1:0] cdata_rd,
   input  logic [2:0]    csel,
   input  logic          rb_sel,
   input  logic [AW-1:0] rb_addr,
   output logic [DW-1:0] rb_data,
   output logic          done,
   output logic [12:0]   wr_cnt_l0,
   output logic [10:0]   wr_cnt_l1,
   output logic [3:0]    err
);

   localparam int TW = $clog2(RDY_TIMEOUT + 1);

   state_t        state;
   logic [TW-1:0] tmo_cnt;

   logic          in_run, in_load;
   logic          sel_l0, sel_l1, l1_addr_ok;
   logic          img_we, l0_we, l1_we;
   logic [DW-1:0] l0_rd, l0_rb, l1_rd, l1_rb;
   logic [DW-1:0] img_unused_rd;

   // NOTE: every signal written here gets a default first, so no path
   // through the block can leave one unassigned and infer a latch.
   always_comb begin
      in_run     = (state == ST_RUN);
      in_load    = (state == ST_IDLE) || (state == ST_DONE);
      sel_l0     = (csel == CSEL_L0);
      sel_l1     = (csel == CSEL_L1);
      l1_addr_ok = (caddr_wr < AW'(L1_DEPTH));
      img_we     = ld_we && in_load;
      l0_we      = cwr && in_run && sel_l0;
      l1_we      = cwr && in_run && sel_l1 && l1_addr_ok;

      // Banks are read before the edge that writes them, so a same-cycle
      // cwr/crd to one address naturally returns the old word.
      cdata_rd = '0;
      if (crd && in_run) begin
         if (sel_l0)      cdata_rd = l0_rd;
         else if (sel_l1) cdata_rd = l1_rd;
      end

      rb_data = rb_sel ? l1_rb : l0_rb;
   end

   conv_bank_ram #(.DEPTH(L0_DEPTH), .AW(AW), .DW(DW)) u_img (
      .clk       (clk),
      .we        (img_we),
      .wr_addr   (ld_addr),
      .wr_data   (ld_data),
      .rd_a_addr (iaddr),
      .rd_a_data (idata),
      .rd_b_addr (iaddr),
      .rd_b_data (img_unused_rd)
   );

   conv_bank_ram #(.DEPTH(L0_DEPTH), .AW(AW), .DW(DW)) u_l0 (
      .clk       (clk),
      .we        (l0_we),
      .wr_addr   (caddr_wr),
      .wr_data   (cdata_wr),
      .rd_a_addr (caddr_rd),
      .rd_a_data (l0_rd),
      .rd_b_addr (rb_addr),
      .rd_b_data (l0_rb)
   );

   conv_bank_ram #(.DEPTH(L1_DEPTH), .AW(AW), .DW(DW)) u_l1 (
      .clk       (clk),
      .we        (l1_we),
      .wr_addr   (caddr_wr),
      .wr_data   (cdata_wr),
      .rd_a_addr (caddr_rd),
      .rd_a_data (l1_rd),
      .rd_b_addr (rb_addr),
      .rd_b_data (l1_rb)
   );

   // NOTE: state is updated with non-blocking assignments only, so every
   // decision in this block sees the values from before the edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         ready     <= 1'b0;
         done      <= 1'b0;
         wr_cnt_l0 <= '0;
         wr_cnt_l1 <= '0;
         err       <= '0;
         tmo_cnt   <= '0;
      end else begin
         done <= 1'b0;

         if (l0_we && (wr_cnt_l0 != '1)) wr_cnt_l0 <= wr_cnt_l0 + 1'b1;
         if (l1_we && (wr_cnt_l1 != '1)) wr_cnt_l1 <= wr_cnt_l1 + 1'b1;

         if ((ld_we && !in_load) || ((cwr || crd) && !in_run))
            err[ERR_PROTO] <= 1'b1;
         if ((cwr || crd) && in_run && !sel_l0 && !sel_l1)
            err[ERR_CSEL] <= 1'b1;
         if (cwr && in_run && sel_l1 && !l1_addr_ok)
            err[ERR_ADDR] <= 1'b1;

         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state     <= ST_READY;
                  ready     <= 1'b1;
                  wr_cnt_l0 <= '0;
                  wr_cnt_l1 <= '0;
                  tmo_cnt   <= '0;
               end
            end
            ST_READY: begin
               if (busy) begin
                  state <= ST_RUN;
                  ready <= 1'b0;
               end else if (tmo_cnt == TW'(RDY_TIMEOUT - 1)) begin
                  state        <= ST_IDLE;
                  ready        <= 1'b0;
                  err[ERR_TMO] <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (!busy) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
